uart_la_cmd_decoder: RTL and testbench

Host-command receiver for the UART logic analyzer. It sits between the UART receiver and the capture/readout logic, and is the inbound counterpart of the FIFO-to-UART readout controller. It parses framed command bytes (header, command, payload, checksum) and updates the capture configuration registers. It also issues one-cycle start, stop and dump pulses; a dump pulse selects the channel whose FIFO the readout controller drains over UART.

---
 rtl/uart_la_pkg.sv | 23 ++
 rtl/uart_la_cmd_len.sv | 22 ++
 rtl/uart_la_cmd_decoder.sv | 155 +++++++++++++++
 tb/tb_uart_la_cmd_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_la_pkg.sv
// Shared definitions for the logic-analyzer host command path: opcodes,
// error codes and the frame-parser state encoding.
package uart_la_pkg;

  localparam logic [7:0] CMD_START    = 8'h01;
  localparam logic [7:0] CMD_STOP     = 8'h02;
  localparam logic [7:0] CMD_SET_DIV  = 8'h03;
  localparam logic [7:0] CMD_SET_TRIG = 8'h04;
  localparam logic [7:0] CMD_DUMP     = 8'h05;

  localparam logic [1:0] ERR_OPCODE  = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ARG     = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StPay,
    StCsum
  } state_e;

endpackage

// File: rtl/uart_la_cmd_len.sv
// Opcode lookup: reports whether an opcode is known and how many payload
// bytes follow it in a frame.
module uart_la_cmd_len
  import uart_la_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       valid,
  output logic [1:0] len
);

  always_comb begin
    valid = 1'b1;
    len   = 2'd0;
    case (opcode)
      CMD_START, CMD_SET_TRIG, CMD_DUMP: len = 2'd1;
      CMD_STOP:                          len = 2'd0;
      CMD_SET_DIV:                       len = 2'd2;
      default:                           valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_la_cmd_decoder.sv
// Host command receiver: parses HEADER/CMD/payload/CSUM frames from the UART
// and commits capture configuration only on fully valid frames.
module uart_la_cmd_decoder
  import uart_la_pkg::*;
#(
  parameter logic [7:0]  HEADER         = 8'h55,
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter logic [15:0] DIV_RESET      = 16'd1
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [3:0]  ch_en,
  output logic [15:0] sample_div,
  output logic [1:0]  trig_ch,
  output logic        trig_rise,
  output logic        trig_en,
  output logic        capture_start,
  output logic        capture_stop,
  output logic [3:0]  dump_en,
  output logic        cmd_ok,
  output logic        cmd_err,
  output logic [1:0]  err_code
);

  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  state_e        state;
  logic [7:0]    opcode;
  logic [7:0]    csum;
  logic [15:0]   payload;
  logic [1:0]    pay_cnt;
  logic [1:0]    pay_len;
  logic [TW-1:0] to_cnt;

  logic       len_valid;
  logic [1:0] len;
  logic       arg_bad;
  logic       timeout;

  uart_la_cmd_len u_cmd_len (
    .opcode (rx_data),
    .valid  (len_valid),
    .len    (len)
  );

  always_comb begin
    arg_bad = 1'b0;
    case (opcode)
      CMD_START:   arg_bad = (payload[3:0] == 4'd0);
      CMD_SET_DIV: arg_bad = (payload == 16'd0);
      CMD_DUMP:    arg_bad = (payload[7:2] != 6'd0);
      default:     arg_bad = 1'b0;
    endcase
  end

  // A byte on the limit cycle beats the timeout.
  assign timeout = (state != StIdle) && !rx_done && (to_cnt == TO_LIMIT);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state         <= StIdle;
      opcode        <= 8'd0;
      csum          <= 8'd0;
      payload       <= 16'd0;
      pay_cnt       <= 2'd0;
      pay_len       <= 2'd0;
      to_cnt        <= '0;
      ch_en         <= 4'd0;
      sample_div    <= DIV_RESET;
      trig_ch       <= 2'd0;
      trig_rise     <= 1'b0;
      trig_en       <= 1'b0;
      capture_start <= 1'b0;
      capture_stop  <= 1'b0;
      dump_en       <= 4'd0;
      cmd_ok        <= 1'b0;
      cmd_err       <= 1'b0;
      err_code      <= ERR_OPCODE;
    end else begin
      capture_start <= 1'b0;
      capture_stop  <= 1'b0;
      dump_en       <= 4'd0;
      cmd_ok        <= 1'b0;
      cmd_err       <= 1'b0;

      if (state == StIdle || rx_done) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (timeout) begin
        cmd_err  <= 1'b1;
        err_code <= ERR_TIMEOUT;
        state    <= StIdle;
      end else if (rx_done) begin
        unique case (state)
          StIdle: begin
            if (rx_data == HEADER) state <= StCmd;
          end
          StCmd: begin
            if (len_valid) begin
              opcode  <= rx_data;
              csum    <= rx_data;
              pay_cnt <= 2'd0;
              pay_len <= len;
              state   <= (len == 2'd0) ? StCsum : StPay;
            end else begin
              cmd_err  <= 1'b1;
              err_code <= ERR_OPCODE;
              state    <= StIdle;
            end
          end
          StPay: begin
            payload <= {payload[7:0], rx_data};
            csum    <= csum ^ rx_data;
            pay_cnt <= pay_cnt + 2'd1;
            if (pay_cnt == pay_len - 2'd1) state <= StCsum;
          end
          StCsum: begin
            state <= StIdle;
            if (rx_data != csum) begin
              cmd_err  <= 1'b1;
              err_code <= ERR_CSUM;
            end else if (arg_bad) begin
              cmd_err  <= 1'b1;
              err_code <= ERR_ARG;
            end else begin
              cmd_ok <= 1'b1;
              case (opcode)
                CMD_START: begin
                  ch_en         <= payload[3:0];
                  capture_start <= 1'b1;
                end
                CMD_STOP:    capture_stop <= 1'b1;
                CMD_SET_DIV: sample_div   <= payload;
                CMD_SET_TRIG: begin
                  trig_ch   <= payload[1:0];
                  trig_rise <= payload[2];
                  trig_en   <= payload[3];
                end
                CMD_DUMP: dump_en <= 4'b0001 << payload[1:0];
                default:  cmd_ok  <= 1'b1;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_la_cmd_decoder.sv
// Self-checking bench: directed and random host frames compared against a
// frame-level reference model of the command protocol.
module tb_uart_la_cmd_decoder;

  localparam logic [7:0]  HDR  = 8'h55;
  localparam int unsigned TO   = 16;
  localparam logic [15:0] DIVR = 16'h00A5;

  logic        clk = 1'b0;
  logic        reset_p = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [3:0]  ch_en;
  logic [15:0] sample_div;
  logic [1:0]  trig_ch;
  logic        trig_rise;
  logic        trig_en;
  logic        capture_start;
  logic        capture_stop;
  logic [3:0]  dump_en;
  logic        cmd_ok;
  logic        cmd_err;
  logic [1:0]  err_code;

  uart_la_cmd_decoder #(
    .HEADER         (HDR),
    .TIMEOUT_CYCLES (TO),
    .DIV_RESET      (DIVR)
  ) dut (
    .clk           (clk),
    .reset_p       (reset_p),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .ch_en         (ch_en),
    .sample_div    (sample_div),
    .trig_ch       (trig_ch),
    .trig_rise     (trig_rise),
    .trig_en       (trig_en),
    .capture_start (capture_start),
    .capture_stop  (capture_stop),
    .dump_en       (dump_en),
    .cmd_ok        (cmd_ok),
    .cmd_err       (cmd_err),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [3:0]  exp_ch_en;
  logic [15:0] exp_div;
  logic [1:0]  exp_trig_ch;
  logic        exp_rise, exp_tren, exp_start, exp_stop, exp_ok, exp_err;
  logic [3:0]  exp_dump;
  logic [1:0]  exp_code;

  function automatic int op_len(input logic [7:0] op);
    case (op)
      8'h01: return 1;
      8'h02: return 0;
      8'h03: return 2;
      8'h04: return 1;
      8'h05: return 1;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".ch_en"}, 16'(ch_en), 16'(exp_ch_en));
    chk({ph, ".sample_div"}, sample_div, exp_div);
    chk({ph, ".trig_ch"}, 16'(trig_ch), 16'(exp_trig_ch));
    chk({ph, ".trig_rise"}, 16'(trig_rise), 16'(exp_rise));
    chk({ph, ".trig_en"}, 16'(trig_en), 16'(exp_tren));
    chk({ph, ".capture_start"}, 16'(capture_start), 16'(exp_start));
    chk({ph, ".capture_stop"}, 16'(capture_stop), 16'(exp_stop));
    chk({ph, ".dump_en"}, 16'(dump_en), 16'(exp_dump));
    chk({ph, ".cmd_ok"}, 16'(cmd_ok), 16'(exp_ok));
    chk({ph, ".cmd_err"}, 16'(cmd_err), 16'(exp_err));
    chk({ph, ".err_code"}, 16'(err_code), 16'(exp_code));
  endtask

  task automatic clear_pulses();
    exp_start = 1'b0;
    exp_stop  = 1'b0;
    exp_dump  = 4'd0;
    exp_ok    = 1'b0;
    exp_err   = 1'b0;
  endtask

  task automatic model_reset();
    exp_ch_en   = 4'd0;
    exp_div     = DIVR;
    exp_trig_ch = 2'd0;
    exp_rise    = 1'b0;
    exp_tren    = 1'b0;
    exp_code    = 2'd0;
    clear_pulses();
  endtask

  // Byte strobe for one cycle; back-to-back calls give back-to-back strobes.
  task automatic put(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send a whole frame (payload MSB first) and check the outcome.
  task automatic run_frame(input logic [7:0] op, input logic [15:0] pl,
                           input logic [7:0] csum_flip, input string tag);
    int n;
    logic [7:0] cs;
    logic bad;
    n = op_len(op);
    put(HDR);
    clear_pulses();
    check_all({tag, ".hdr"});
    put(op);
    if (n < 0) begin
      exp_err  = 1'b1;
      exp_code = 2'd0;
      check_all({tag, ".opcode"});
      return;
    end
    cs = op;
    if (n == 2) begin
      put(pl[15:8]);
      cs = cs ^ pl[15:8];
    end
    if (n >= 1) begin
      put(pl[7:0]);
      cs = cs ^ pl[7:0];
    end
    put(cs ^ csum_flip);
    bad = (op == 8'h01 && pl[3:0] == 4'd0) || (op == 8'h03 && pl == 16'd0) ||
          (op == 8'h05 && pl[7:2] != 6'd0);
    if (csum_flip != 8'd0) begin
      exp_err  = 1'b1;
      exp_code = 2'd1;
    end else if (bad) begin
      exp_err  = 1'b1;
      exp_code = 2'd3;
    end else begin
      exp_ok = 1'b1;
      case (op)
        8'h01: begin exp_ch_en = pl[3:0]; exp_start = 1'b1; end
        8'h02: exp_stop = 1'b1;
        8'h03: exp_div = pl;
        8'h04: begin exp_trig_ch = pl[1:0]; exp_rise = pl[2]; exp_tren = pl[3]; end
        default: exp_dump[pl[1:0]] = 1'b1;
      endcase
    end
    check_all({tag, ".result"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  op, flip, g;
    logic [15:0] pl;
    int r;
    model_reset();
    idle(3);
    reset_p = 1'b0;
    check_all("reset");

    run_frame(8'h01, 16'h0005, 8'h00, "start");
    idle(1);
    clear_pulses();
    check_all("start_width");
    run_frame(8'h03, 16'h1234, 8'h00, "div");
    run_frame(8'h03, 16'h0000, 8'h00, "div_zero");
    run_frame(8'h05, 16'h0002, 8'h00, "dump2");
    idle(1);
    clear_pulses();
    check_all("dump_width");
    run_frame(8'h05, 16'h0004, 8'h00, "dump_bad");
    run_frame(8'h01, 16'h00F0, 8'h00, "start_zero");
    run_frame(8'h04, 16'h000D, 8'h01, "trig_badcs");
    run_frame(8'h04, 16'h000D, 8'h00, "trig");

    // Timeout inside PAY, then a byte exactly on the limit cycle
    put(HDR); put(8'h03); put(8'h12);
    clear_pulses();
    idle(TO - 1);
    check_all("to_before");
    idle(1);
    exp_err  = 1'b1;
    exp_code = 2'd2;
    check_all("to_fire");
    run_frame(8'h02, 16'h0000, 8'h00, "stop_after_to");
    put(HDR); put(8'h03);
    idle(TO - 1);
    put(8'h12);
    idle(TO - 1);
    put(8'h34);
    put(8'h03 ^ 8'h12 ^ 8'h34);
    clear_pulses();
    exp_ok  = 1'b1;
    exp_div = 16'h1234;
    check_all("to_limit_byte");

    put(8'hAA);
    clear_pulses();
    check_all("garbage");
    run_frame(8'h07, 16'h0000, 8'h00, "unknown_op");

    // Reset mid-frame
    put(HDR); put(8'h01);
    reset_p = 1'b1;
    @(negedge clk);
    reset_p = 1'b0;
    model_reset();
    check_all("reset_mid");
    run_frame(8'h01, 16'h0003, 8'h00, "after_reset");

    // Reset wins over a valid CSUM byte
    put(HDR); put(8'h02);
    rx_data = 8'h02; rx_done = 1'b1; reset_p = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; reset_p = 1'b0;
    model_reset();
    check_all("reset_prio");

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 11);
      if (r == 0) op = (($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(6, 255)));
      else op = 8'($urandom_range(1, 5));
      pl = 16'($urandom);
      r = $urandom_range(0, 5);
      if (r == 0) pl = 16'd0;
      else if (r == 1) pl = {8'($urandom), 6'd0, pl[1:0]};
      flip = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(op, pl, flip, $sformatf("rnd%0d", i));
      r = $urandom_range(0, 3);
      if (r == 3) begin
        g = 8'($urandom);
        if (g == HDR) g = 8'h00;
        put(g);
        clear_pulses();
        check_all($sformatf("rnd%0d.garbage", i));
      end else begin
        idle(r);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
